// File: rtl/survivor_regex.sv
// Register-exchange survivor-path unit: one DEPTH-bit path per trellis state, updated from ACS decisions.
// Define SURVIVOR_BEST_STATE_EN to read out the path of best_state instead of state 0.
module survivor_regex #(
    parameter int M     = 2,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 start,
    input  logic [(1<<M)-1:0]    dec,
    input  logic [M-1:0]         best_state,
    output logic                 out_bit,
    output logic                 out_valid
);

    localparam int STATES = 1 << M;
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [M-1:0]      HALF     = M'(STATES / 2);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(DEPTH - 1);

    logic [STATES-1:0][DEPTH-1:0] path;
    logic [STATES-1:0][DEPTH-1:0] nxt;
    logic [FILL_W-1:0]            fill;
    logic [M-1:0]                 sel;
    logic [STATES-1:0]            unused_path_msb;

    // A start step behaves as if every old path were zero.
    for (genvar s = 0; s < STATES; s++) begin : g_state
        localparam logic [M-1:0] S_IDX = M'(s);
        logic [M-1:0] pred;
        assign pred               = (S_IDX >> 1) | (dec[s] ? HALF : '0);
        assign nxt[s]             = {path[pred][DEPTH-2:0] & {(DEPTH-1){~start}}, S_IDX[0]};
        assign unused_path_msb[s] = path[s][DEPTH-1];
    end

`ifdef SURVIVOR_BEST_STATE_EN
    assign sel = best_state;
`else
    logic [M-1:0] unused_best_state;
    assign unused_best_state = best_state;
    assign sel = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            path      <= '0;
            fill      <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            path      <= nxt;
            out_bit   <= nxt[sel][DEPTH-1];
            out_valid <= ~start && (fill >= FILL_THR);
            if (start) begin
                fill <= FILL_W'(1);
            end else if (fill != FILL_MAX) begin
                fill <= fill + FILL_W'(1);
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_survivor_regex.sv
// Self-checking bench for survivor_regex; the reference model traces each state back through
// the recorded decision history instead of shifting per-state registers.
module tb_survivor_regex;

    localparam int M      = 2;
    localparam int DEPTH  = 8;
    localparam int STATES = 1 << M;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              start = 1'b0;
    logic [STATES-1:0] dec = '0;
    logic [M-1:0]      best_state = '0;
    logic              out_bit;
    logic              out_valid;

    int total = 0;
    int bad = 0;

    logic [STATES-1:0] hist[$];
    logic              exp_bit = 1'b0;
    logic              exp_valid = 1'b0;

    survivor_regex #(.M(M), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .start      (start),
        .dec        (dec),
        .best_state (best_state),
        .out_bit    (out_bit),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    // Path of state s = LSBs of the states visited walking back along the decisions, newest first.
    function automatic logic [DEPTH-1:0] trace(input int s);
        logic [DEPTH-1:0] p;
        int st;
        int idx;
        p  = '0;
        st = s;
        for (int k = 0; k < DEPTH; k++) begin
            idx = hist.size() - 1 - k;
            if (idx < 0) break;
            p[k] = (st % 2) != 0;
            st   = st / 2 + (hist[idx][st] ? STATES / 2 : 0);
        end
        return p;
    endfunction

    task automatic do_cycle(input logic r, input logic iv, input logic st,
                            input logic [STATES-1:0] d, input logic [M-1:0] bs);
        int sel_m;
        @(negedge clk);
        reset = r; in_valid = iv; start = st; dec = d; best_state = bs;
        @(posedge clk);
        #1;
`ifdef SURVIVOR_BEST_STATE_EN
        sel_m = int'(bs);
`else
        sel_m = 0;
`endif
        if (r) begin
            hist.delete();
            exp_bit   = 1'b0;
            exp_valid = 1'b0;
        end else if (iv) begin
            if (st) hist.delete();
            exp_valid = !st && (hist.size() >= DEPTH - 1);
            hist.push_back(d);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            exp_bit = trace(sel_m)[DEPTH-1];
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_cycle(1, 1, 1, '1, '1);
        do_cycle(1, 0, 0, '0, '0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_bit !== 1'b0) begin bad++; $display("FAIL reset_bit got=%b want=0", out_bit); end
        for (int s = 0; s < STATES; s++) begin
            total++;
            if (dut.path[s] !== '0) begin bad++; $display("FAIL reset_path[%0d] got=%h want=0", s, dut.path[s]); end
        end
    endtask

    task automatic test_fill_zero();
        do_cycle(1, 0, 0, '0, '0);
        for (int i = 1; i <= DEPTH; i++) begin
            do_cycle(0, 1, 0, '0, '0);
            total++;
            if (out_valid !== (i == DEPTH)) begin bad++; $display("FAIL fill_valid step=%0d got=%b want=%b", i, out_valid, i == DEPTH); end
            total++;
            if (out_bit !== 1'b0) begin bad++; $display("FAIL fill_bit step=%0d got=%b want=0", i, out_bit); end
        end
        total++;
        if (dut.path[3] !== 8'b0000_0011) begin bad++; $display("FAIL fill_path3 got=%b want=00000011", dut.path[3]); end
    endtask

    task automatic test_alt_dec();
        do_cycle(1, 0, 0, '0, '0);
        for (int i = 1; i <= DEPTH; i++) do_cycle(0, 1, 0, 4'b1010, 2'd3);
        total++; if (dut.path[3] !== 8'hFF) begin bad++; $display("FAIL alt_path3 got=%h want=ff", dut.path[3]); end
        total++; if (dut.path[0] !== 8'h00) begin bad++; $display("FAIL alt_path0 got=%h want=00", dut.path[0]); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL alt_valid got=%b want=1", out_valid); end
`ifdef SURVIVOR_BEST_STATE_EN
        total++; if (out_bit !== 1'b1) begin bad++; $display("FAIL alt_bit got=%b want=1", out_bit); end
`else
        total++; if (out_bit !== 1'b0) begin bad++; $display("FAIL alt_bit got=%b want=0", out_bit); end
`endif
    endtask

    task automatic test_gaps();
        int accepted;
        logic held;
        do_cycle(1, 0, 0, '0, '0);
        accepted = 0;
        for (int i = 0; i < 2 * DEPTH + 4; i++) begin
            held = out_bit;
            do_cycle(0, (i % 2) == 0, 0, 4'b1111, 2'd2);
            if ((i % 2) == 0) accepted++;
            total++;
            if (out_valid !== ((i % 2) == 0 && accepted >= DEPTH)) begin
                bad++; $display("FAIL gap_valid cyc=%0d got=%b want=%b", i, out_valid, (i % 2) == 0 && accepted >= DEPTH);
            end
            if ((i % 2) != 0) begin
                total++;
                if (out_bit !== held) begin bad++; $display("FAIL gap_hold cyc=%0d got=%b want=%b", i, out_bit, held); end
            end
            total++;
            if (out_bit !== exp_bit) begin bad++; $display("FAIL gap_bit cyc=%0d got=%b want=%b", i, out_bit, exp_bit); end
        end
    endtask

    task automatic test_start();
        do_cycle(1, 0, 0, '0, '0);
        for (int i = 0; i < 10; i++) do_cycle(0, 1, 0, STATES'($urandom()), M'($urandom()));
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL start_pre_valid got=%b want=1", out_valid); end
        do_cycle(0, 1, 1, STATES'($urandom()), M'($urandom()));
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL start_valid got=%b want=0", out_valid); end
        for (int s = 0; s < STATES; s++) begin
            total++;
            if (dut.path[s] !== DEPTH'(s % 2)) begin bad++; $display("FAIL start_path[%0d] got=%h want=%h", s, dut.path[s], s % 2); end
        end
        for (int i = 2; i <= DEPTH; i++) begin
            do_cycle(0, 1, 0, STATES'($urandom()), M'($urandom()));
            total++;
            if (out_valid !== (i == DEPTH)) begin bad++; $display("FAIL start_refill step=%0d got=%b want=%b", i, out_valid, i == DEPTH); end
            total++;
            if (out_bit !== exp_bit) begin bad++; $display("FAIL start_bit step=%0d got=%b want=%b", i, out_bit, exp_bit); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 12; i++) do_cycle(0, 1, 0, '1, '1);
        do_cycle(1, 1, 1, STATES'($urandom()), M'($urandom()));
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
        total++; if (out_bit !== 1'b0) begin bad++; $display("FAIL midrst_bit got=%b want=0", out_bit); end
        total++; if (dut.fill !== '0) begin bad++; $display("FAIL midrst_fill got=%0d want=0", dut.fill); end
        for (int s = 0; s < STATES; s++) begin
            total++;
            if (dut.path[s] !== '0) begin bad++; $display("FAIL midrst_path[%0d] got=%h want=0", s, dut.path[s]); end
        end
    endtask

    task automatic test_random();
        logic r, iv, st;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 63) == 0);
            iv = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 15) == 0);
            do_cycle(r, iv, st, STATES'($urandom()), M'($urandom()));
            total++;
            if (out_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, out_valid, exp_valid); end
            total++;
            if (out_bit !== exp_bit) begin bad++; $display("FAIL rnd_bit cyc=%0d got=%b want=%b", i, out_bit, exp_bit); end
            for (int s = 0; s < STATES; s++) begin
                total++;
                if (dut.path[s] !== trace(s)) begin bad++; $display("FAIL rnd_path[%0d] cyc=%0d got=%h want=%h", s, i, dut.path[s], trace(s)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_zero();
        test_alt_dec();
        test_gaps();
        test_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/survivor_regex.md
Name: survivor_regex

Overview:
- Parametrised register-exchange survivor-path unit for the Viterbi decoder; the generalised successor of the fixed 4-state, 3-bit path register.
- Holds one DEPTH-bit survivor path per trellis state (2^M states).
- Updates all paths each accepted trellis step from the ACS decision bits.
- Emits one decoded bit per accepted step once the paths are full; sits directly after the ACS array.

Parameters:
- M, 2, encoder memory order; STATES = 2^M (localparam), M >= 1.
- DEPTH, 8, survivor path length in bits (decoding delay), DEPTH >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  dec is valid this cycle; a step is accepted.
- start  input  1  frame start; effective only when in_valid=1.
- dec  input  STATES  ACS decision bits; dec[s] is the decision for state s.
- best_state  input  M  state index whose path is read out (used only with the optional feature).
- out_bit  output  1  decoded bit, registered.
- out_valid  output  1  out_bit valid this cycle, registered.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (reset=1 at a clk edge): all paths <= 0, fill counter <= 0, out_bit <= 0, out_valid <= 0. Reset overrides in_valid and start and may be asserted mid-stream.
- Predecessor of state s: pred(s) = (s >> 1) + dec[s]*(STATES/2).
- Appended bit for state s: s[0].
- Next path: nxt[s] = {path[pred(s)][DEPTH-2:0], s[0]}. All states update in the same cycle and read only old path values (no chained update).
- in_valid=0: paths, fill counter and out_bit hold; out_valid <= 0.
- in_valid=1, start=0: path[s] <= nxt[s] for all s; fill <= min(fill+1, DEPTH).
- in_valid=1, start=1: nxt is computed from all-zero old paths, so path[s] <= {0...0, s[0]}; fill <= 1.
- Readout state sel: 0 by default; best_state with the optional feature.
- out_bit <= nxt[sel][DEPTH-1] on every accepted step.
- out_valid <= 1 iff the step is accepted and the fill value before the step is >= DEPTH-1 (with start=1 this means DEPTH-1 <= 0, which never holds for DEPTH >= 2).
- Latency: first out_valid is asserted in the cycle after the DEPTH-th accepted step following reset or start. After that, out_valid is asserted one cycle after every accepted step.
- Fill counter saturates at DEPTH and never wraps. Counter width is clog2(DEPTH+1).
- Gaps in in_valid do not reset fill.

Optional Feature:
- Macro: SURVIVOR_BEST_STATE_EN.
- Defined: sel = best_state, sampled in the same cycle as in_valid. This implements best-metric traceout.
- Undefined: sel = 0 (fixed-state traceout). The best_state port remains but is ignored, so both builds have the same port list.

Test Plan:
- M=2, DEPTH=8; reset, then 8 accepted steps with dec=4'b0000 -> out_valid=0 after steps 1-7; out_valid=1, out_bit=0 in the cycle after step 8; internal path[3]=8'b00000011.
- dec=4'b1010, best_state=3 for 8 steps -> path[3]=8'hFF and path[0]=8'h00. First out_valid has out_bit=1 with SURVIVOR_BEST_STATE_EN defined, out_bit=0 without it.
- dec=4'b1111, in_valid toggled 1,0,1,0,... -> out_valid first asserted one cycle after the 8th accepted step, never on idle cycles; out_bit holds during gaps.
- After 10 steps (out_valid streaming), start=1 with in_valid=1 -> next cycle out_valid=0; path[s]={0,s[0]}; out_valid returns one cycle after the 8th step counting the start step.
- reset=1 asserted mid-stream together with in_valid=1 and start=1 -> next cycle out_bit=0, out_valid=0, all paths 0, fill=0; the step is discarded.
- M=3, DEPTH=16 build, dec=8'hAA for 16 steps, best_state=7 (macro on) -> out_valid=1 in the cycle after step 16 with out_bit=1; path[7]=16'hFFFF.
